// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP constants, flag indices, issue FSM states and flag decode.
package fp_pkg;

  localparam int SP_BIAS = 127;
  localparam int HP_BIAS = 15;

  localparam logic [31:0] SP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] SP_PINF = 32'h7F80_0000;
  localparam logic [31:0] SP_NINF = 32'hFF80_0000;
  localparam logic [15:0] HP_QNAN = 16'h7E00;
  localparam logic [15:0] HP_PINF = 16'h7C00;
  localparam logic [15:0] HP_NINF = 16'hFC00;

  localparam int FLAG_NAN  = 2;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_ZERO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // single=1 decodes the binary32 fields, otherwise the binary16 fields in [15:0]
  function automatic logic [2:0] decode_flags(input logic [31:0] re, input logic single);
    logic       exp_ones;
    logic       exp_zero;
    logic       man_zero;
    logic [2:0] f;
    if (single) begin
      exp_ones = &re[30:23];
      exp_zero = ~|re[30:23];
      man_zero = ~|re[22:0];
    end else begin
      exp_ones = &re[14:10];
      exp_zero = ~|re[14:10];
      man_zero = ~|re[9:0];
    end
    f            = '0;
    f[FLAG_NAN]  = exp_ones && !man_zero;
    f[FLAG_INF]  = exp_ones && man_zero;
    f[FLAG_ZERO] = exp_zero && man_zero;
    return f;
  endfunction

endpackage

// File: rtl/fmul_fifo.sv
// rtl/fmul_fifo.sv - request FIFO; combinational head, wrap-bit pointers.
module fmul_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 66
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage needs no reset: contents are only visible once a pointer says so
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fmul_issue.sv
// rtl/fmul_issue.sv - queues multiply requests, drives an external multiplier, returns flagged results.
module fmul_issue #(
  parameter int DEPTH   = 2,
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_mode,
  input  logic        in_round,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_mode,
  output logic        mul_round,
  input  logic [31:0] mul_re,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_re,
  output logic [2:0]  out_flags,
  output logic        busy
);

  import fp_pkg::*;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  cnt;
  logic        ready_en;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        capture;
  logic [65:0] head;

  // ready_en keeps in_ready low while reset is held and for nothing longer
  assign in_ready  = ready_en && !fifo_full;
  assign push      = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = !fifo_empty || (state != ST_IDLE);

  fmul_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (66)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data ({in_a, in_b, in_mode, in_round}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == 2'd0) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // back-to-back issue on the handshake cycle sustains one result per MUL_LAT+1
        if (out_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = ST_WAIT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a     <= '0;
      mul_b     <= '0;
      mul_mode  <= 1'b0;
      mul_round <= 1'b0;
      cnt       <= '0;
      out_re    <= '0;
      out_flags <= '0;
    end else begin
      if (pop) begin
        mul_a     <= head[65:34];
        mul_b     <= head[33:2];
        mul_mode  <= head[1];
        mul_round <= head[0];
        cnt       <= 2'(MUL_LAT - 1);
      end else if (state == ST_WAIT && cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end
      if (capture) begin
        out_re    <= mul_mode ? mul_re : {16'h0000, mul_re[15:0]};
        out_flags <= decode_flags(mul_re, mul_mode);
      end
    end
  end

endmodule

// File: doc/fmul_issue.md
FMUL_ISSUE -- requirements
Module: fmul_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 2: input FIFO depth in entries, a power of two, at least 2.
REQ-002 SHALL have parameter MUL_LAT, default 1: cycles from driving mul_* to sampling mul_re, range 1..4.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  request offered; in_ready  output  1  request accepted when both are high.
REQ-006 in_a, in_b  input  32 each  operands (half mode uses [15:0]); in_mode  input  1  0=half, 1=single; in_round  input  1  0=truncate, 1=round-nearest-even.
REQ-007 mul_a, mul_b  output  32 each; mul_mode, mul_round  output  1 each  registered operands driven into the multiplier.
REQ-008 mul_re  input  32  multiplier result (half result in [15:0]).
REQ-009 out_valid  output  1; out_ready  input  1; out_re  output  32  result; out_flags  output  3  {nan, inf, zero}.
REQ-010 busy  output  1  high whenever the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-011 The FIFO SHALL be written on in_valid&&in_ready; in_ready = !full, independent of same-cycle pops.
REQ-012 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-013 IDLE with FIFO non-empty: pop head, load mul_* registers, cnt<=MUL_LAT-1, go to WAIT; otherwise stay in IDLE.
REQ-014 WAIT: if cnt==0, register out_re<=mul_re and out_flags, go to DONE; else cnt<=cnt-1.
REQ-015 DONE: out_valid=1; out_re and out_flags stay stable until out_ready.
REQ-016 DONE with out_ready: if FIFO non-empty, pop and load into WAIT in the same cycle; else go to IDLE.
REQ-017 mul_* SHALL hold their last loaded value outside load cycles.
REQ-018 Latency from acceptance into an empty idle block to out_valid SHALL be MUL_LAT+2 cycles.
REQ-019 With out_ready held high, throughput SHALL be one result per MUL_LAT+1 cycles.
REQ-020 Half mode: out_re[31:16] SHALL be forced to 0; flags SHALL decode exponent [14:10] and mantissa [9:0].
REQ-021 Single mode: flags SHALL decode exponent [30:23] and mantissa [22:0].
REQ-022 Flag decode: nan = exponent all-ones and mantissa !=0; inf = exponent all-ones and mantissa ==0; zero = exponent ==0 and mantissa ==0; at most one flag set.
REQ-023 Full FIFO with a pop in the same cycle: in_ready SHALL stay 0 that cycle and no write occurs.

Reset
REQ-024 rst_n low SHALL asynchronously force: FSM to IDLE, FIFO empty, cnt=0, out_valid=0, out_re=0, out_flags=0, mul_* all 0, busy=0, in_ready=0.
REQ-025 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-026 Reset mid-operation SHALL discard all queued and in-flight requests; nothing is produced after release without new input.

Structure
REQ-027 A shared package fp_pkg SHALL hold: biases 127/15; NaN/Inf constants 0x7FC00000, 0x7F800000, 0xFF800000, 0x7E00, 0x7C00, 0xFC00; flag bit indices NAN=2, INF=1, ZERO=0; the FSM state enum.
REQ-028 The FIFO SHALL be one sub-module, fmul_fifo: synchronous, parameterised by DEPTH and width 66, same clk/rst_n.
REQ-029 The multiplier SHALL be instantiated outside fmul_issue and connected through the mul_* ports.

Verification
REQ-030 Single-mode multiply: 0x40000000 x 0x40400000, mode=1, MUL_LAT=1 -> out_re=0x40C00000, flags=000, out_valid 3 cycles after acceptance.
REQ-031 Half-mode multiply: 0x4000 x 0x4200, mode=0 -> out_re=0x00004600, flags=000.
REQ-032 Special cases: 0x7F800000 x 0x7FC00001 -> out_re=0x7FC00000, flags=100; 0x00000000 x 0x3F800000 -> out_re=0x00000000, flags=001.
REQ-033 Backpressure: hold out_ready=0 and offer 4 requests with DEPTH=2 -> one request in DONE, 2 in the FIFO, in_ready=0; results drain in order when out_ready=1.
REQ-034 Reset mid-operation: assert rst_n=0 during WAIT with 2 requests queued -> all outputs 0 immediately; after release, out_valid stays 0 and busy=0.
